mem_upload: RTL and testbench
=============================

MEM_UPLOAD -- requirements
Module: mem_upload

Interface
REQ-001 SHALL have parameter RAM_SNAP_INDEX, default 8'd7: ioctl_index value that selects a RAM snapshot upload.
REQ-002 SHALL have parameter RAM_SNAP_BYTES, default 131072: size of the RAM snapshot window in bytes.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports clk_sys in 1 (system clock) and reset in 1 (synchronous reset).
REQ-004 SHALL have input ce_ref, 1 bit: SDRAM slot strobe.
REQ-005 SHALL have inputs ioctl_upload (1 bit, upload active), ioctl_rd (1 bit, byte read request), ioctl_addr (25 bits, byte address) and ioctl_index (8 bits, upload target).
REQ-006 SHALL have outputs ioctl_din (8 bits, returned byte) and ioctl_wait (1 bit, host stall).
REQ-007 SHALL have outputs mem_rd (1 bit, SDRAM read strobe), mem_addr (23 bits), mem_bank (2 bits) and busy (1 bit, SDRAM port owned by uploader); input mem_dout, 8 bits, is SDRAM read data.
REQ-008 SHALL have output chk_sum, 8 bits: running checksum (see Configuration).

Function
REQ-009 SHALL implement FSM states IDLE, REQ, DATA, DONE.
REQ-010 IDLE -> REQ SHALL occur on an ioctl_rd rising edge with ioctl_upload=1 and a mapped address; ioctl_addr and ioctl_index are latched in that cycle and ioctl_wait=1 from the next cycle.
REQ-011 REQ SHALL drive mem_rd=1, busy=1 and the mapped mem_addr/mem_bank, and move to DATA on the first ce_ref.
REQ-012 DATA SHALL drop mem_rd, capture mem_dout into ioctl_din on the next ce_ref, and move to DONE.
REQ-013 DONE SHALL clear ioctl_wait and busy, then return to IDLE after one cycle.
REQ-014 ioctl_index[4:0]<4 SHALL use the ROM map: ioctl_addr[24:14] 0/1/2/3 -> mem_addr[22:14] = 9'h000/9'h100/9'h107/9'h0FF, with mem_addr[13:0]=ioctl_addr[13:0] and mem_bank=0.
REQ-015 ioctl_index==RAM_SNAP_INDEX with addr<RAM_SNAP_BYTES SHALL map to mem_addr=zero-extended ioctl_addr and mem_bank=2'b00.
REQ-016 Unmapped addresses or indices SHALL return ioctl_din=8'hFF without touching SDRAM: ioctl_wait high for exactly one cycle, then DONE.
REQ-017 ioctl_rd rising while ioctl_wait=1 SHALL be ignored.
REQ-018 ioctl_upload falling in any state SHALL abort to IDLE next cycle with mem_rd=0, busy=0 and ioctl_wait=0; ioctl_din SHALL hold its value.
REQ-019 A ce_ref arriving in the same cycle as entry to REQ SHALL NOT count; the strobe must occur while in REQ.
REQ-020 ioctl_rd with ioctl_upload=0 SHALL be ignored.

Reset
REQ-021 Reset SHALL force state=IDLE, ioctl_din=8'hFF, ioctl_wait=0, mem_rd=0, busy=0, mem_addr=0, mem_bank=0 and chk_sum=0.
REQ-022 Reset mid-operation SHALL take priority over all transitions, including a simultaneous ce_ref.

Configuration
REQ-023 With UPLOAD_CHECKSUM_EN defined, chk_sum SHALL add each returned byte (mod 256) on entry to DONE, and clear on the ioctl_upload rising edge.
REQ-024 Without UPLOAD_CHECKSUM_EN, chk_sum SHALL be constant 8'h00 and no checksum register SHALL exist.

Structure
REQ-025 Package mem_upload_pkg SHALL hold the FSM state enum, ROM page constants (OS 9'h000, BASIC 9'h100, AMSDOS 9'h107, MF2 9'h0FF) and the ROM-index limit 5'd4.
REQ-026 Combinational sub-module upload_addr_map SHALL convert {ioctl_index, ioctl_addr} into {mapped, mem_addr, mem_bank}.

Verification
REQ-027 Scenario: index 0, addr 25'h04005, ce_ref every 8 cycles, mem_dout=8'h3C -> mem_addr=23'h400005 and mem_rd for one ce_ref period; ioctl_din=8'h3C; ioctl_wait falls in DONE.
REQ-028 Scenario: index 0, addr 25'h10000 -> no mem_rd; ioctl_din=8'hFF; ioctl_wait high exactly one cycle.
REQ-029 Scenario: index 7, addr 25'h1FFFF then 25'h20000 -> first read issues mem_addr=23'h01FFFF, second returns 8'hFF.
REQ-030 Scenario: ioctl_upload dropped while in DATA -> IDLE next cycle; mem_rd=0, busy=0, ioctl_wait=0; ioctl_din unchanged.
REQ-031 Scenario: second ioctl_rd pulse while ioctl_wait=1 -> ignored; exactly one mem_rd sequence.
REQ-032 Scenario (UPLOAD_CHECKSUM_EN): read bytes 8'hF0, 8'h20 -> chk_sum=8'h10; a new ioctl_upload rise -> chk_sum=8'h00.

Source files
------------

// File: rtl/mem_upload_pkg.sv
// Shared definitions for the ROM/RAM upload path: FSM states, ROM page bases
// and the highest ioctl_index (exclusive) that selects the ROM map.
package mem_upload_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [8:0] PAGE_OS     = 9'h000;
  localparam logic [8:0] PAGE_BASIC  = 9'h100;
  localparam logic [8:0] PAGE_AMSDOS = 9'h107;
  localparam logic [8:0] PAGE_MF2    = 9'h0FF;

  localparam logic [4:0] ROM_INDEX_LIMIT = 5'd4;

endpackage

// File: rtl/upload_addr_map.sv
// Combinational translation of a host upload request {index, byte address}
// into an SDRAM location. ROM indices map four 16 KiB pages onto their fixed
// SDRAM pages; the RAM snapshot index maps a flat window starting at zero.
module upload_addr_map
  import mem_upload_pkg::*;
#(
  parameter logic [7:0]  RAM_SNAP_INDEX = 8'd7,
  parameter int unsigned RAM_SNAP_BYTES = 131072
) (
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  output logic        mapped,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_bank
);

  logic [8:0] page;

  // Decode the request; anything not matched stays unmapped with a zero address.
  always_comb begin
    mapped   = 1'b0;
    mem_addr = '0;
    mem_bank = 2'b00;
    page     = PAGE_OS;
    if (ioctl_index[4:0] < ROM_INDEX_LIMIT) begin
      mapped = 1'b1;
      case (ioctl_addr[24:14])
        11'd0:   page = PAGE_OS;
        11'd1:   page = PAGE_BASIC;
        11'd2:   page = PAGE_AMSDOS;
        11'd3:   page = PAGE_MF2;
        default: mapped = 1'b0;
      endcase
      if (mapped) begin
        mem_addr = {page, ioctl_addr[13:0]};
      end
    end else if (ioctl_index == RAM_SNAP_INDEX &&
                 {7'd0, ioctl_addr} < RAM_SNAP_BYTES) begin
      mapped   = 1'b1;
      mem_addr = ioctl_addr[22:0];
    end
  end

endmodule

// File: rtl/mem_upload.sv
// Host upload bridge: serves single-byte ioctl reads from SDRAM, stalling the
// host with ioctl_wait while one SDRAM slot (ce_ref) issues the read and the
// next slot returns the data. Unmapped requests answer 8'hFF immediately.
// Optional feature macro: UPLOAD_CHECKSUM_EN adds a running byte checksum.
module mem_upload
  import mem_upload_pkg::*;
#(
  parameter logic [7:0]  RAM_SNAP_INDEX = 8'd7,
  parameter int unsigned RAM_SNAP_BYTES = 131072
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_ref,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_index,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        mem_rd,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_bank,
  output logic        busy,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  chk_sum
);

  state_e      state_q, state_d;
  logic        rd_prev_q;
  logic        mapped_q, mapped_d;
  logic [22:0] addr_q, addr_d;
  logic [1:0]  bank_q, bank_d;
  logic [7:0]  din_q, din_d;

  logic        map_hit;
  logic [22:0] map_addr;
  logic [1:0]  map_bank;
  logic        rd_rise;

  upload_addr_map #(
    .RAM_SNAP_INDEX(RAM_SNAP_INDEX),
    .RAM_SNAP_BYTES(RAM_SNAP_BYTES)
  ) u_map (
    .ioctl_index(ioctl_index),
    .ioctl_addr (ioctl_addr),
    .mapped     (map_hit),
    .mem_addr   (map_addr),
    .mem_bank   (map_bank)
  );

  assign rd_rise = ioctl_rd & ~rd_prev_q;

  // Next-state logic; an unmapped request passes through REQ for a single
  // cycle with SDRAM untouched, and dropping ioctl_upload aborts everything.
  always_comb begin
    state_d  = state_q;
    mapped_d = mapped_q;
    addr_d   = addr_q;
    bank_d   = bank_q;
    din_d    = din_q;
    case (state_q)
      IDLE: begin
        if (ioctl_upload && rd_rise) begin
          state_d  = REQ;
          mapped_d = map_hit;
          if (map_hit) begin
            addr_d = map_addr;
            bank_d = map_bank;
          end
        end
      end
      REQ: begin
        if (!mapped_q) begin
          din_d   = 8'hFF;
          state_d = DONE;
        end else if (ce_ref) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (ce_ref) begin
          din_d   = mem_dout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!ioctl_upload && state_q != IDLE) begin
      state_d = IDLE;
      din_d   = din_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_prev_q <= 1'b0;
      mapped_q  <= 1'b0;
      addr_q    <= '0;
      bank_q    <= 2'b00;
      din_q     <= 8'hFF;
    end else begin
      state_q   <= state_d;
      rd_prev_q <= ioctl_rd;
      mapped_q  <= mapped_d;
      addr_q    <= addr_d;
      bank_q    <= bank_d;
      din_q     <= din_d;
    end
  end

  assign ioctl_wait = (state_q == REQ) || (state_q == DATA);
  assign mem_rd     = (state_q == REQ) && mapped_q;
  assign busy       = ioctl_wait && mapped_q;
  assign mem_addr   = addr_q;
  assign mem_bank   = bank_q;
  assign ioctl_din  = din_q;

`ifdef UPLOAD_CHECKSUM_EN
  logic       upload_prev_q;
  logic [7:0] chk_q;

  // Accumulate each returned byte as DONE is entered; restart on a new upload.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      upload_prev_q <= 1'b0;
      chk_q         <= 8'h00;
    end else begin
      upload_prev_q <= ioctl_upload;
      if (ioctl_upload && !upload_prev_q) begin
        chk_q <= 8'h00;
      end else if (state_d == DONE && state_q != DONE) begin
        chk_q <= chk_q + din_d;
      end
    end
  end

  assign chk_sum = chk_q;
`else
  assign chk_sum = 8'h00;
`endif

endmodule

// File: tb/tb_mem_upload.sv
// Bench for mem_upload: directed scenarios with literal expectations plus a
// randomized read/abort mix checked every cycle against a behavioural model.
module tb_mem_upload;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce_ref = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_index = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_rd;
  logic [22:0] mem_addr;
  logic [1:0]  mem_bank;
  logic        busy;
  logic [7:0]  mem_dout = '0;
  logic [7:0]  chk_sum;

  int checks = 0;
  int errors = 0;

  mem_upload dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ce_ref      (ce_ref),
    .ioctl_upload(ioctl_upload),
    .ioctl_rd    (ioctl_rd),
    .ioctl_addr  (ioctl_addr),
    .ioctl_index (ioctl_index),
    .ioctl_din   (ioctl_din),
    .ioctl_wait  (ioctl_wait),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_bank    (mem_bank),
    .busy        (busy),
    .mem_dout    (mem_dout),
    .chk_sum     (chk_sum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slot strobe / read data generator ----------------
  int         ce_mode = 0;   // 0: every 8 cycles, 1: random, 2: driven by main
  bit         dout_rand = 1'b0;
  logic [7:0] dout_fix = 8'h00;
  int         cyc = 0;

  always @(negedge clk_sys) begin
    cyc++;
    if (ce_mode == 0) ce_ref = (cyc % 8 == 0);
    else if (ce_mode == 1) ce_ref = ($urandom_range(0, 3) == 0);
    mem_dout = dout_rand ? 8'($urandom) : dout_fix;
  end

  // ---------------- behavioural reference model ----------------
  function automatic void ref_map(input logic [7:0] idx, input logic [24:0] a,
                                  output bit hit, output logic [22:0] ma);
    int blk;
    int page;
    blk = int'(a) / 16384;
    hit = 1'b0;
    ma  = '0;
    if (int'(idx) % 32 < 4) begin
      case (blk)
        0: page = 'h000;
        1: page = 'h100;
        2: page = 'h107;
        3: page = 'h0FF;
        default: page = -1;
      endcase
      if (page >= 0) begin
        hit = 1'b1;
        ma  = 23'(page * 16384 + int'(a) % 16384);
      end
    end else if (idx == 8'd7 && int'(a) < 131072) begin
      hit = 1'b1;
      ma  = 23'(a);
    end
  endfunction

  // strobes_left: 0 idle, 2 waiting for issue slot, 1 waiting for data slot,
  // -1 finished (one cycle with wait released)
  int         m_left = 0;
  bit         m_hit = 1'b0;
  logic [22:0] m_addr = '0;
  logic [7:0] m_din = 8'hFF;
  logic [7:0] m_chk = 8'h00;
  bit         m_rd_prev = 1'b0;
  bit         m_up_prev = 1'b0;
  bit         cmp_en = 1'b0;

  always @(posedge clk_sys) begin
    bit ret;
    bit hit;
    logic [22:0] ma;
    ret = 1'b0;
    if (reset) begin
      m_left = 0; m_hit = 1'b0; m_addr = '0; m_din = 8'hFF; m_chk = 8'h00;
      m_rd_prev = 1'b0; m_up_prev = 1'b0;
    end else begin
      if (m_left != 0 && !ioctl_upload) begin
        m_left = 0;
      end else if (m_left == 0) begin
        if (ioctl_upload && ioctl_rd && !m_rd_prev) begin
          ref_map(ioctl_index, ioctl_addr, hit, ma);
          m_hit  = hit;
          m_left = 2;
          if (hit) m_addr = ma;
        end
      end else if (m_left == -1) begin
        m_left = 0;
      end else if (!m_hit) begin
        m_din = 8'hFF; ret = 1'b1; m_left = -1;
      end else if (ce_ref) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_din = mem_dout; ret = 1'b1; m_left = -1;
        end
      end
`ifdef UPLOAD_CHECKSUM_EN
      if (ioctl_upload && !m_up_prev) m_chk = 8'h00;
      else if (ret) m_chk = m_chk + m_din;
`endif
      m_rd_prev = ioctl_rd;
      m_up_prev = ioctl_upload;
    end
  end

  // Compare every cycle, just after the active edge.
  always @(posedge clk_sys) begin
    #1;
    if (cmp_en) begin
      check("m_wait", ioctl_wait, (m_left > 0));
      check("m_mem_rd", mem_rd, (m_left == 2 && m_hit));
      check("m_busy", busy, (m_left > 0 && m_hit));
      check("m_din", ioctl_din, m_din);
      check("m_addr", mem_addr, m_addr);
      check("m_bank", mem_bank, 2'b00);
      check("m_chk", chk_sum, m_chk);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_read(input logic [7:0] idx, input logic [24:0] a,
                         output int wcyc, output int rdcyc, output logic [22:0] seen);
    @(negedge clk_sys);
    ioctl_index = idx; ioctl_addr = a; ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    wcyc = 0; rdcyc = 0; seen = '0;
    for (int t = 0; t < 100 && ioctl_wait; t++) begin
      wcyc++;
      if (mem_rd) begin rdcyc++; seen = mem_addr; end
      @(negedge clk_sys);
    end
    if (ioctl_wait) check("read_timeout", 1, 0);
    @(negedge clk_sys);
  endtask

  int          wc, rc, rises;
  logic [22:0] sa;
  logic        prev_rd;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    check("rst_din", ioctl_din, 8'hFF);
    check("rst_wait", ioctl_wait, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_bank", mem_bank, 0);
    check("rst_chk", chk_sum, 0);
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk_sys);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);

    // model self-pin: ROM and RAM map arithmetic
    begin
      bit h; logic [22:0] m;
      ref_map(8'd2, 25'h0C001, h, m);
      check("pin_map_mf2", {h, 8'h0, m}, {1'b1, 8'h0, 23'h3FC001});
      ref_map(8'd7, 25'h20000, h, m);
      check("pin_map_ram_end", h, 0);
    end

    // ROM page 1 read via SDRAM
    ce_mode = 0; dout_fix = 8'h3C;
    do_read(8'd0, 25'h04005, wc, rc, sa);
    check("rom_addr", sa, 23'h400005);
    check("rom_rd_len", (rc >= 1 && rc <= 8), 1);
    check("rom_din", ioctl_din, 8'h3C);
    check("rom_wait_done", ioctl_wait, 0);

    // ROM block out of range
    do_read(8'd0, 25'h10000, wc, rc, sa);
    check("unm_wait_len", wc, 1);
    check("unm_rd", rc, 0);
    check("unm_din", ioctl_din, 8'hFF);

    // RAM snapshot window edges
    dout_fix = 8'hA5;
    do_read(8'd7, 25'h1FFFF, wc, rc, sa);
    check("ram_last_addr", sa, 23'h01FFFF);
    check("ram_last_din", ioctl_din, 8'hA5);
    do_read(8'd7, 25'h20000, wc, rc, sa);
    check("ram_over_din", ioctl_din, 8'hFF);
    check("ram_over_rd", rc, 0);

    // abort while in DATA
    dout_fix = 8'h5A;
    @(negedge clk_sys);
    ioctl_index = 8'd0; ioctl_addr = 25'h0C123; ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    for (int t = 0; t < 40 && !(ioctl_wait && !mem_rd); t++) @(negedge clk_sys);
    check("abort_in_data", (ioctl_wait && busy && !mem_rd), 1);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("abort_wait", ioctl_wait, 0);
    check("abort_busy", busy, 0);
    check("abort_rd", mem_rd, 0);
    check("abort_din", ioctl_din, 8'hFF);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);

    // second rd pulse while stalled
    rises = 0; prev_rd = 1'b0;
    ioctl_index = 8'd1; ioctl_addr = 25'h00010; ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (t == 2) ioctl_rd = 1'b1;
      if (t == 3) ioctl_rd = 1'b0;
      if (mem_rd && !prev_rd) rises++;
      prev_rd = mem_rd;
      @(negedge clk_sys);
    end
    check("dup_rd_seq", rises, 1);
    check("dup_idle", ioctl_wait, 0);

    // checksum
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    dout_fix = 8'hF0;
    do_read(8'd0, 25'h00001, wc, rc, sa);
    dout_fix = 8'h20;
    do_read(8'd0, 25'h00002, wc, rc, sa);
`ifdef UPLOAD_CHECKSUM_EN
    check("chk_sum2", chk_sum, 8'h10);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check("chk_clear", chk_sum, 8'h00);
`else
    check("chk_const", chk_sum, 8'h00);
`endif

    // reset mid-REQ coinciding with a slot strobe
    ce_mode = 2; ce_ref = 1'b0;
    @(negedge clk_sys);
    ioctl_index = 8'd0; ioctl_addr = 25'h00100; ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check("rstmid_req", mem_rd, 1);
    reset = 1'b1; ce_ref = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0; ce_ref = 1'b0;
    check("rstmid_wait", ioctl_wait, 0);
    check("rstmid_rd", mem_rd, 0);
    check("rstmid_din", ioctl_din, 8'hFF);
    check("rstmid_addr", mem_addr, 0);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);

    // randomized mix
    dout_rand = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [7:0]  idx;
      logic [24:0] a;
      int          k;
      ce_mode = $urandom_range(0, 1);
      case ($urandom_range(0, 4))
        0: idx = 8'($urandom_range(0, 3));
        1: idx = 8'd7;
        2: idx = 8'h27;
        3: idx = 8'h21;
        default: idx = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: a = 25'($urandom_range(0, 'hFFFF));
        1: a = 25'h0FFFF;
        2: a = 25'h10000;
        3: a = 25'h1FFFF;
        4: a = 25'h20000;
        default: a = 25'($urandom);
      endcase
      k = $urandom_range(0, 9);
      @(negedge clk_sys);
      ioctl_index = idx; ioctl_addr = a; ioctl_rd = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      for (int t = 0; t < 80 && ioctl_wait; t++) begin
        if (k == 0 && t == 2) ioctl_upload = 1'b0;
        if (k == 1 && t == 1) ioctl_rd = 1'b1;
        if (k == 1 && t == 2) ioctl_rd = 1'b0;
        @(negedge clk_sys);
      end
      if (ioctl_wait) check("rand_timeout", 1, 0);
      ioctl_rd = 1'b0;
      ioctl_upload = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk_sys);
    end

    repeat (4) @(negedge clk_sys);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
